// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter and sequencer for the shared memory controller (optional MEM_ARB_WATCHDOG_EN stall watchdog)
module mem_arbiter #(
  parameter int MAX_SKIP = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_address,
  output logic [31:0] if_data,
  output logic        if_ready,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [31:0] d_address,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic [31:0] mem_address,
  output logic [31:0] mem_input_data,
  output logic        mem_write,
  output logic        mem_type,
  input  logic [31:0] mem_output_data,
  input  logic        mem_stall,
  output logic        timeout_err
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BUSY_IF = 2'd1;
  localparam logic [1:0] S_BUSY_D  = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic MEM_ROM = 1'b0;
  localparam logic MEM_RAM = 1'b1;

  logic [1:0]  state_q, state_d;
  logic [3:0]  skip_q, skip_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic        is_d_q, is_d_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        done_now;
  logic [31:0] cap_data;

`ifdef MEM_ARB_WATCHDOG_EN
  localparam int WD_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
`endif

  // Grant selection in IDLE, stall wait and read-data capture in BUSY, one-cycle DONE
  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    write_d   = write_q;
    is_d_d    = is_d_q;
    if_data_d = if_data_q;
    d_rdata_d = d_rdata_q;
    done_now  = 1'b0;
    cap_data  = '0;
`ifdef MEM_ARB_WATCHDOG_EN
    wd_d      = '0;
    err_d     = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        // Data wins unless fetch has already been passed over MAX_SKIP times in a row
        if (d_req && (!if_req || (skip_q < 4'(MAX_SKIP)))) begin
          state_d = S_BUSY_D;
          is_d_d  = 1'b1;
          addr_d  = d_address;
          wdata_d = d_wdata;
          write_d = d_write;
          skip_d  = if_req ? (skip_q + 4'd1) : 4'd0;
        end else if (if_req) begin
          state_d = S_BUSY_IF;
          is_d_d  = 1'b0;
          addr_d  = if_address;
          write_d = 1'b0;
          skip_d  = 4'd0;
        end
      end
      S_BUSY_IF, S_BUSY_D: begin
        done_now = !mem_stall;
        cap_data = mem_output_data;
`ifdef MEM_ARB_WATCHDOG_EN
        // A controller stuck in stall is abandoned: the requester gets zero data
        if (mem_stall) begin
          if (wd_q == WD_W'(TIMEOUT - 1)) begin
            done_now = 1'b1;
            cap_data = '0;
            err_d    = 1'b1;
          end else begin
            wd_d = wd_q + WD_W'(1);
          end
        end
`endif
        if (done_now) begin
          state_d = S_DONE;
          if (state_q == S_BUSY_D) d_rdata_d = cap_data;
          else                     if_data_d = cap_data;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      skip_q    <= 4'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      is_d_q    <= 1'b0;
      if_data_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      skip_q    <= skip_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      is_d_q    <= is_d_d;
      if_data_q <= if_data_d;
      d_rdata_q <= d_rdata_d;
    end
  end

`ifdef MEM_ARB_WATCHDOG_EN
  // Consecutive-stall counter and sticky timeout flag
  always_ff @(posedge clock) begin
    if (!reset) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign timeout_err = err_q;
`else
  assign timeout_err = 1'b0;
`endif

  // Address and write data are register outputs, so they hold between transactions
  assign mem_address    = addr_q;
  assign mem_input_data = wdata_q;
  assign mem_write      = (state_q == S_BUSY_D) && write_q;
  assign mem_type       = (state_q == S_BUSY_D) ? MEM_RAM : MEM_ROM;
  assign if_ready       = (state_q == S_DONE) && !is_d_q;
  assign d_ready        = (state_q == S_DONE) && is_d_q;
  assign if_data        = if_data_q;
  assign d_rdata        = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter: directed cases plus randomized request rounds
module tb_mem_arbiter;

  localparam int MAX_SKIP = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_address;
  logic [31:0] if_data;
  logic        if_ready;
  logic        d_req;
  logic        d_write;
  logic [31:0] d_address;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic [31:0] mem_address;
  logic [31:0] mem_input_data;
  logic        mem_write;
  logic        mem_type;
  logic [31:0] mem_output_data;
  logic        mem_stall;
  logic        timeout_err;

  typedef struct packed {
    logic        is_d;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  int          checks = 0;
  int          errors = 0;
  txn_t        exp_q[$];
  logic [63:0] store_q[$];
  bit          sb_on = 1'b0;
  bit          stall_rand = 1'b0;
  logic        stall_r = 1'b0;
  logic        stall_dir;
  int          stall_run = 0;
  bit          force_en;
  logic [31:0] mem_rdata_force;
  int          model_skip = 0;
  txn_t        mon_e;
  logic [63:0] mon_s;

  always #5 clock = ~clock;

  mem_arbiter #(.MAX_SKIP(MAX_SKIP), .TIMEOUT(8)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_address(if_address), .if_data(if_data), .if_ready(if_ready),
    .d_req(d_req), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_address(mem_address), .mem_input_data(mem_input_data), .mem_write(mem_write),
    .mem_type(mem_type), .mem_output_data(mem_output_data), .mem_stall(mem_stall),
    .timeout_err(timeout_err)
  );

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  assign mem_output_data = force_en ? mem_rdata_force : mem_fn(mem_address);
  assign mem_stall       = stall_rand ? stall_r : stall_dir;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // Random stall runs of at most 3 cycles, changed away from both clock edges
  always @(posedge clock) begin
    if (stall_rand) begin
      #2;
      if (stall_run >= 3 || $urandom_range(0, 2) != 0) begin
        stall_r   = 1'b0;
        stall_run = 0;
      end else begin
        stall_r   = 1'b1;
        stall_run++;
      end
    end
  end

  // Monitor: logs completed stores on the memory side, checks every ready pulse against the queue
  always @(negedge clock) begin
    if (sb_on) begin
      if (mem_type && mem_write && !mem_stall) store_q.push_back({mem_address, mem_input_data});
      if (if_ready || d_ready) begin
        chk("ready_overlap", {31'd0, if_ready & d_ready}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: ready pulse if=%0d d=%0d, expected none", if_ready, d_ready);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb_port", {31'd0, d_ready}, {31'd0, mon_e.is_d});
          if (!mon_e.wr) begin
            chk("sb_rdata", mon_e.is_d ? d_rdata : if_data, mem_fn(mon_e.addr));
          end else if (store_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_store_missing: no store on bus, expected addr %h", mon_e.addr);
          end else begin
            mon_s = store_q.pop_front();
            chk("sb_store_addr", mon_s[63:32], mon_e.addr);
            chk("sb_store_wdata", mon_s[31:0], mon_e.wdata);
          end
        end
      end
    end
  end

  task automatic wait_ready(input bit is_d);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(is_d ? d_ready : if_ready) && n < 500);
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: port d=%0d saw no ready in 500 cycles, expected a pulse", is_d);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  endtask

  // Each port issues its transactions back to back; expected completion order comes
  // from the arbitration rule (or a fixed list for the starvation case)
  task automatic run_round(input int n_if, input int n_d, input bit starve);
    txn_t ifs[$];
    txn_t ds[$];
    txn_t t;
    int   ii = 0;
    int   di = 0;
    bit   starve_order [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    for (int k = 0; k < n_if; k++) begin
      t.is_d = 1'b0; t.wr = 1'b0; t.addr = $urandom; t.wdata = '0;
      ifs.push_back(t);
    end
    for (int k = 0; k < n_d; k++) begin
      t.is_d = 1'b1; t.wr = 1'($urandom_range(0, 1)); t.addr = $urandom; t.wdata = $urandom;
      ds.push_back(t);
    end
    if (starve) begin
      for (int k = 0; k < 10; k++) begin
        if (starve_order[k]) begin exp_q.push_back(ds[di]); di++; end
        else begin exp_q.push_back(ifs[ii]); ii++; end
      end
      model_skip = 0;
    end else begin
      while (ii < n_if || di < n_d) begin
        if (di < n_d && (ii >= n_if || model_skip < MAX_SKIP)) begin
          exp_q.push_back(ds[di]);
          di++;
          model_skip = (ii < n_if) ? model_skip + 1 : 0;
        end else begin
          exp_q.push_back(ifs[ii]);
          ii++;
          model_skip = 0;
        end
      end
    end
    fork
      begin
        for (int k = 0; k < n_if; k++) begin
          if_address = ifs[k].addr;
          if_req = 1'b1;
          wait_ready(1'b0);
        end
        if_req = 1'b0;
      end
      begin
        for (int k = 0; k < n_d; k++) begin
          d_address = ds[k].addr;
          d_write   = ds[k].wr;
          d_wdata   = ds[k].wdata;
          d_req     = 1'b1;
          wait_ready(1'b1);
        end
        d_req = 1'b0;
        d_write = 1'b0;
      end
    join
  endtask

  initial begin
    reset = 1'b0; if_req = 1'b1; d_req = 1'b1; if_address = 32'h80; d_address = 32'h200;
    d_write = 1'b0; d_wdata = '0; stall_dir = 1'b0; force_en = 1'b0; mem_rdata_force = '0;

    // Reset with both requests pending
    tick();
    chk("rst_if_ready", {31'd0, if_ready}, 0);
    chk("rst_d_ready", {31'd0, d_ready}, 0);
    chk("rst_mem_write", {31'd0, mem_write}, 0);
    chk("rst_mem_type", {31'd0, mem_type}, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_input_data", mem_input_data, 0);
    chk("rst_if_data", if_data, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_timeout_err", {31'd0, timeout_err}, 0);
    tick();
    chk("rst2_ready", {30'd0, if_ready, d_ready}, 0);
    reset = 1'b1;
    tick();
    chk("first_grant_type", {31'd0, mem_type}, 1);
    chk("first_grant_addr", mem_address, 32'h200);
    tick();
    chk("first_d_ready", {31'd0, d_ready}, 1);
    chk("first_d_rdata", d_rdata, mem_fn(32'h200));
    if_req = 1'b0; d_req = 1'b0;
    tick();

    // Single fetch, no stall
    force_en = 1'b1; mem_rdata_force = 32'h0050_0093;
    if_address = 32'h40; if_req = 1'b1;
    tick();
    chk("fetch_mem_type", {31'd0, mem_type}, 0);
    chk("fetch_mem_write", {31'd0, mem_write}, 0);
    chk("fetch_mem_address", mem_address, 32'h40);
    chk("fetch_early_ready", {31'd0, if_ready}, 0);
    tick();
    chk("fetch_if_ready", {31'd0, if_ready}, 1);
    chk("fetch_if_data", if_data, 32'h0050_0093);
    chk("fetch_no_d_ready", {31'd0, d_ready}, 0);
    if_req = 1'b0; force_en = 1'b0;
    tick();

    // Store with three stall cycles
    d_req = 1'b1; d_write = 1'b1; d_address = 32'h100; d_wdata = 32'hDEAD_BEEF; stall_dir = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("store_mem_write", {31'd0, mem_write}, 1);
      chk("store_mem_address", mem_address, 32'h100);
      chk("store_mem_input_data", mem_input_data, 32'hDEAD_BEEF);
      chk("store_early_ready", {31'd0, d_ready}, 0);
      if (k == 4) stall_dir = 1'b0;
    end
    tick();
    chk("store_d_ready", {31'd0, d_ready}, 1);
    chk("store_done_mem_write", {31'd0, mem_write}, 0);
    d_req = 1'b0; d_write = 1'b0;
    tick();

    // Starvation guard with both ports requesting continuously
    sb_on = 1'b1;
    run_round(2, 8, 1'b1);
    tick();
    sb_on = 1'b0;
    chk("starve_drained", exp_q.size(), 0);

    // Reset while a stalled store is in flight
    d_req = 1'b1; d_write = 1'b1; d_address = 32'h300; d_wdata = 32'h1234_5678; stall_dir = 1'b1;
    tick();
    tick();
    chk("midrst_busy_write", {31'd0, mem_write}, 1);
    reset = 1'b0;
    tick();
    chk("midrst_d_ready", {31'd0, d_ready}, 0);
    chk("midrst_mem_write", {31'd0, mem_write}, 0);
    chk("midrst_mem_address", mem_address, 0);
    chk("midrst_d_rdata", d_rdata, 0);
    d_req = 1'b0; d_write = 1'b0; reset = 1'b1; stall_dir = 1'b0;
    tick();
    chk("midrst_after1", {31'd0, d_ready}, 0);
    tick();
    chk("midrst_after2", {31'd0, d_ready}, 0);
    if_address = 32'h44; if_req = 1'b1;
    tick();
    chk("postrst_fetch_early", {31'd0, if_ready}, 0);
    tick();
    chk("postrst_fetch_ready", {31'd0, if_ready}, 1);
    chk("postrst_fetch_data", if_data, mem_fn(32'h44));
    if_req = 1'b0;
    tick();

`ifdef MEM_ARB_WATCHDOG_EN
    // Fetch against a controller stuck in stall
    chk("wd_err_clear", {31'd0, timeout_err}, 0);
    if_address = 32'h80; if_req = 1'b1; stall_dir = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("wd_wait_if_ready", {31'd0, if_ready}, 0);
    end
    tick();
    chk("wd_if_ready", {31'd0, if_ready}, 1);
    chk("wd_if_data", if_data, 0);
    chk("wd_err_set", {31'd0, timeout_err}, 1);
    if_req = 1'b0; stall_dir = 1'b0;
    tick();
    if_address = 32'h84; if_req = 1'b1;
    tick();
    tick();
    chk("wd_next_if_ready", {31'd0, if_ready}, 1);
    chk("wd_next_if_data", if_data, mem_fn(32'h84));
    chk("wd_err_sticky", {31'd0, timeout_err}, 1);
    if_req = 1'b0;
    tick();
`else
    chk("no_wd_err", {31'd0, timeout_err}, 0);
`endif

    // Randomized rounds with random stalls
    model_skip = 0;
    sb_on = 1'b1;
    stall_rand = 1'b1;
    for (int r = 0; r < 40; r++) begin
      int n_if = $urandom_range(0, 3);
      int n_d  = $urandom_range(0, 6);
      if (n_if == 0 && n_d == 0) n_d = 1;
      run_round(n_if, n_d, 1'b0);
    end
    tick();
    stall_rand = 1'b0;
    tick();
    sb_on = 1'b0;
    chk("random_drained", exp_q.size(), 0);
    chk("stores_drained", store_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
